// File: rtl/zx_spi_master_if.sv
// CPU I/O bus bundle seen by the SPI master: request strobes, address and write data.
`timescale 1ns/1ps

interface zx_spi_master_if;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;

    modport master (
        output ioreq,
        output rd,
        output wr,
        output a_reg,
        output d_reg
    );

    modport slave (
        input ioreq,
        input rd,
        input wr,
        input a_reg,
        input d_reg
    );
endinterface

// File: rtl/zx_spi_master.sv
// SPI master for SD/flash peripherals on the Z80 I/O bus: programmable SCK
// divider, N active-low chip selects, busy/overrun status and CPU wait output.
`timescale 1ns/1ps

module zx_spi_master #(
    parameter int         CS_COUNT  = 2,
    parameter int         DIV_W     = 4,
    parameter logic [DIV_W-1:0] DIV_RESET = '0,
    parameter logic [7:0] PORT_DATA = 8'hEB,
    parameter logic [7:0] PORT_CTRL = 8'hE7,
    parameter logic [7:0] PORT_DIV  = 8'hEF
) (
    input  logic                clk28,
    input  logic                rst_n,
    input  logic                en,
    zx_spi_master_if.slave      bus,
    output logic [7:0]          d_out,
    output logic                d_out_active,
    input  logic                spi_miso,
    output logic                spi_mosi,
    output logic                spi_sck,
    output logic [CS_COUNT-1:0] spi_cs_n,
    output logic                spi_wait
);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Bus-side registers
    logic                accData_q;
    logic                accCtrl_q;
    logic                accDiv_q;
    logic [CS_COUNT-1:0] csN_q;
    logic [DIV_W-1:0]    div_q;
    logic [7:0]          dOut_q;
    logic                dOutActive_q;
    logic                overrun_q;

    // Shift engine registers
    state_t              state_q;
    logic                busy_q;
    logic                sck_q;
    logic                mosi_q;
    logic                misoBit_q;
    logic [7:0]          shift_q;
    logic [7:0]          rxByte_q;
    logic [DIV_W-1:0]    divLat_q;
    logic [DIV_W-1:0]    halfCnt_q;
    logic [2:0]          bitCnt_q;

    // Decoded strobes and single-cycle access edges
    logic       accData;
    logic       accCtrl;
    logic       accDiv;
    logic       dataEdge;
    logic       ctrlEdge;
    logic       divEdge;
    logic       dataRead;
    logic       divRead;
    logic       startXfer;
    logic [7:0] txByte;
    logic [7:0] statusByte;
    logic       unusedAddrHi;

    assign accData  = en & bus.ioreq & (bus.a_reg[7:0] == PORT_DATA) & (bus.rd | bus.wr);
    assign accCtrl  = en & bus.ioreq & (bus.a_reg[7:0] == PORT_CTRL) & (bus.rd | bus.wr);
    assign accDiv   = en & bus.ioreq & (bus.a_reg[7:0] == PORT_DIV)  & (bus.rd | bus.wr);

    assign dataEdge = accData & ~accData_q;
    assign ctrlEdge = accCtrl & ~accCtrl_q;
    assign divEdge  = accDiv  & ~accDiv_q;

    assign dataRead = dataEdge & ~bus.wr;
    assign divRead  = divEdge  & ~bus.wr;

    // A data access only launches a byte when the engine is idle; reads send 0xFF
    assign startXfer  = dataEdge & ~busy_q;
    assign txByte     = bus.wr ? bus.d_reg : 8'hFF;
    assign statusByte = {6'b000000, overrun_q, busy_q};

    // The upper address byte is not part of the port decode
    assign unusedAddrHi = ^bus.a_reg[15:8];

    // Port decode side: edge-detect history, chip selects, divider, read data and overrun
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            accData_q    <= 1'b0;
            accCtrl_q    <= 1'b0;
            accDiv_q     <= 1'b0;
            csN_q        <= '1;
            div_q        <= DIV_RESET;
            dOut_q       <= 8'h00;
            dOutActive_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            accData_q    <= accData;
            accCtrl_q    <= accCtrl;
            accDiv_q     <= accDiv;
            dOutActive_q <= (accData | accDiv) & bus.rd;

            if (ctrlEdge && bus.wr) begin
                csN_q <= bus.d_reg[CS_COUNT-1:0];
            end

            if (divEdge && bus.wr) begin
                div_q <= bus.d_reg[DIV_W-1:0];
            end

            if (dataRead) begin
                dOut_q <= rxByte_q;
            end else if (divRead) begin
                dOut_q <= statusByte;
            end

            if (dataEdge && busy_q) begin
                overrun_q <= 1'b1;
            end else if (divRead) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Mode-0 shift engine: toggle SCK every div_lat+1 cycles, sample on rise, shift on fall
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            misoBit_q <= 1'b0;
            shift_q   <= 8'hFF;
            rxByte_q  <= 8'hFF;
            divLat_q  <= '0;
            halfCnt_q <= '0;
            bitCnt_q  <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    sck_q  <= 1'b0;
                    mosi_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (startXfer) begin
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                        shift_q   <= txByte;
                        mosi_q    <= txByte[7];
                        divLat_q  <= div_q;
                        halfCnt_q <= '0;
                        bitCnt_q  <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (halfCnt_q == divLat_q) begin
                        halfCnt_q <= '0;
                        sck_q     <= ~sck_q;
                        if (!sck_q) begin
                            misoBit_q <= spi_miso;
                        end else begin
                            shift_q <= {shift_q[6:0], misoBit_q};
                            if (bitCnt_q == 3'd7) begin
                                rxByte_q <= {shift_q[6:0], misoBit_q};
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                                mosi_q   <= 1'b1;
                            end else begin
                                bitCnt_q <= bitCnt_q + 3'd1;
                                mosi_q   <= shift_q[6];
                            end
                        end
                    end else begin
                        halfCnt_q <= halfCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out        = dOut_q;
    assign d_out_active = dOutActive_q;
    assign spi_mosi     = mosi_q;
    assign spi_sck      = sck_q;
    assign spi_cs_n     = csN_q;
    assign spi_wait     = busy_q;

endmodule

// File: tb/tb_zx_spi_master.sv
// Self-checking bench for zx_spi_master: directed scenarios plus randomized
// transfers checked against a simple SPI slave / register model.
`timescale 1ns/1ps

module tb_zx_spi_master;

    localparam int         CS_COUNT  = 2;
    localparam int         DIV_W     = 4;
    localparam logic [7:0] PORT_DATA = 8'hEB;
    localparam logic [7:0] PORT_CTRL = 8'hE7;
    localparam logic [7:0] PORT_DIV  = 8'hEF;

    logic                clk28 = 1'b0;
    logic                rst_n = 1'b1;
    logic                en    = 1'b1;
    logic                spi_miso;
    logic [7:0]          d_out;
    logic                d_out_active;
    logic                spi_mosi;
    logic                spi_sck;
    logic                spi_wait;
    logic [CS_COUNT-1:0] spi_cs_n;

    int checks = 0;
    int passed = 0;

    // Reference model state: divider in force and last completed received byte
    int         modelDiv = 0;
    logic [7:0] modelRx  = 8'hFF;

    // Slave side: loopback or a fixed byte presented MSB first
    bit         loopback  = 1'b1;
    logic [7:0] slaveByte = 8'h00;

    // Cumulative observation counters, sampled on the falling clock edge
    int         busyCycles = 0;
    int         riseCount  = 0;
    int         highCycles = 0;
    int         busyRises  = 0;
    int         fallCnt    = 0;
    logic [7:0] mosiBits   = 8'h00;
    logic       sckPrev    = 1'b0;
    logic       waitPrev   = 1'b0;

    zx_spi_master_if bus ();

    zx_spi_master #(
        .CS_COUNT (CS_COUNT),
        .DIV_W    (DIV_W),
        .DIV_RESET(4'd0),
        .PORT_DATA(PORT_DATA),
        .PORT_CTRL(PORT_CTRL),
        .PORT_DIV (PORT_DIV)
    ) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .en          (en),
        .bus         (bus),
        .d_out       (d_out),
        .d_out_active(d_out_active),
        .spi_miso    (spi_miso),
        .spi_mosi    (spi_mosi),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_wait    (spi_wait)
    );

    always #18 clk28 = ~clk28;

    assign spi_miso = loopback ? spi_mosi :
                      ((fallCnt < 8) ? slaveByte[3'(7 - fallCnt)] : 1'b1);

    // Watch the serial lines and busy, and step the slave's bit pointer on SCK falls
    always @(negedge clk28) begin
        if (spi_wait && !waitPrev) begin
            busyRises = busyRises + 1;
            fallCnt   = 0;
        end
        if (spi_wait) busyCycles = busyCycles + 1;
        if (spi_sck) highCycles = highCycles + 1;
        if (spi_sck && !sckPrev) begin
            riseCount = riseCount + 1;
            mosiBits  = {mosiBits[6:0], spi_mosi};
        end
        if (!spi_sck && sckPrev) fallCnt = fallCnt + 1;
        sckPrev  = spi_sck;
        waitPrev = spi_wait;
    end

    // One CPU I/O cycle: strobe held for a single clock, read data sampled before release
    task automatic applyStimulus(input bit isWrite, input logic [7:0] addr, input logic [7:0] data,
                                 output logic [7:0] rdata, output logic ract);
        @(negedge clk28);
        bus.ioreq = 1'b1;
        bus.a_reg = {8'h00, addr};
        bus.d_reg = data;
        bus.wr    = isWrite;
        bus.rd    = ~isWrite;
        @(negedge clk28);
        rdata     = d_out;
        ract      = d_out_active;
        bus.ioreq = 1'b0;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
    endtask

    // Bounded wait for the engine to go idle
    task automatic waitIdle(output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk28);
            if (!spi_wait) begin
                timedOut = 1'b0;
                break;
            end
        end
        @(negedge clk28);
    endtask

    task automatic test_reset();
        logic [7:0] rdat;
        logic       ract;
        bus.ioreq = 1'b0;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.a_reg = 16'h0000;
        bus.d_reg = 8'h00;
        #5 rst_n = 1'b0;
        repeat (2) @(negedge clk28);
        checks++; if (spi_cs_n !== 2'b11) $display("[TB] FAIL reset_cs: got %b, expected 11", spi_cs_n); else passed++;
        checks++; if (spi_sck !== 1'b0) $display("[TB] FAIL reset_sck: got %b, expected 0", spi_sck); else passed++;
        checks++; if (spi_mosi !== 1'b1) $display("[TB] FAIL reset_mosi: got %b, expected 1", spi_mosi); else passed++;
        checks++; if (spi_wait !== 1'b0) $display("[TB] FAIL reset_wait: got %b, expected 0", spi_wait); else passed++;
        checks++; if (d_out !== 8'h00) $display("[TB] FAIL reset_dout: got %h, expected 00", d_out); else passed++;
        checks++; if (d_out_active !== 1'b0) $display("[TB] FAIL reset_dact: got %b, expected 0", d_out_active); else passed++;
        rst_n = 1'b1;
        @(negedge clk28);
        applyStimulus(1'b0, PORT_DIV, 8'h00, rdat, ract);
        checks++; if (rdat !== 8'h00) $display("[TB] FAIL reset_status: got %h, expected 00", rdat); else passed++;
    endtask

    task automatic test_write_loopback();
        int b0, r0, h0;
        logic [7:0] rdat;
        logic       ract;
        bit         tmo;
        loopback = 1'b1;
        b0 = busyCycles; r0 = riseCount; h0 = highCycles;
        applyStimulus(1'b1, PORT_DATA, 8'hA5, rdat, ract);
        waitIdle(tmo);
        modelRx = 8'hA5;
        checks++; if (tmo) $display("[TB] FAIL loop_timeout: busy still %b, expected 0", spi_wait); else passed++;
        checks++; if (busyCycles - b0 !== 16 * (modelDiv + 1)) $display("[TB] FAIL loop_busy: got %0d, expected %0d", busyCycles - b0, 16 * (modelDiv + 1)); else passed++;
        checks++; if (riseCount - r0 !== 8) $display("[TB] FAIL loop_rises: got %0d, expected 8", riseCount - r0); else passed++;
        checks++; if (mosiBits !== 8'hA5) $display("[TB] FAIL loop_mosi: got %h, expected a5", mosiBits); else passed++;
        checks++; if (highCycles - h0 !== 8 * (modelDiv + 1)) $display("[TB] FAIL loop_sckhigh: got %0d, expected %0d", highCycles - h0, 8 * (modelDiv + 1)); else passed++;
        applyStimulus(1'b0, PORT_DATA, 8'h00, rdat, ract);
        checks++; if (rdat !== modelRx) $display("[TB] FAIL loop_read: got %h, expected %h", rdat, modelRx); else passed++;
        checks++; if (ract !== 1'b1) $display("[TB] FAIL loop_dact: got %b, expected 1", ract); else passed++;
        waitIdle(tmo);
        modelRx = 8'hFF;
    endtask

    task automatic test_divider();
        int b0, h0;
        logic [7:0] rdat;
        logic       ract;
        bit         tmo;
        applyStimulus(1'b1, PORT_DIV, 8'h03, rdat, ract);
        modelDiv  = 3;
        loopback  = 1'b0;
        slaveByte = 8'h00;
        b0 = busyCycles; h0 = highCycles;
        applyStimulus(1'b1, PORT_DATA, 8'h3C, rdat, ract);
        waitIdle(tmo);
        modelRx = slaveByte;
        checks++; if (busyCycles - b0 !== 64) $display("[TB] FAIL div_busy: got %0d, expected 64", busyCycles - b0); else passed++;
        checks++; if (highCycles - h0 !== 32) $display("[TB] FAIL div_sckhigh: got %0d, expected 32", highCycles - h0); else passed++;
        checks++; if (mosiBits !== 8'h3C) $display("[TB] FAIL div_mosi: got %h, expected 3c", mosiBits); else passed++;
        b0 = busyCycles;
        applyStimulus(1'b0, PORT_DATA, 8'h00, rdat, ract);
        checks++; if (rdat !== modelRx) $display("[TB] FAIL div_read: got %h, expected %h", rdat, modelRx); else passed++;
        waitIdle(tmo);
        checks++; if (mosiBits !== 8'hFF) $display("[TB] FAIL div_readahead: got %h, expected ff", mosiBits); else passed++;
        checks++; if (busyCycles - b0 !== 64) $display("[TB] FAIL div_readahead_busy: got %0d, expected 64", busyCycles - b0); else passed++;
        applyStimulus(1'b1, PORT_DIV, 8'h00, rdat, ract);
        modelDiv = 0;
    endtask

    task automatic test_overrun();
        int b0, r0;
        logic [7:0] rdat;
        logic       ract;
        bit         tmo;
        loopback = 1'b1;
        b0 = busyCycles; r0 = riseCount;
        applyStimulus(1'b1, PORT_DATA, 8'h5A, rdat, ract);
        repeat (3) @(negedge clk28);
        applyStimulus(1'b1, PORT_DATA, 8'hC3, rdat, ract);
        applyStimulus(1'b0, PORT_DIV, 8'h00, rdat, ract);
        checks++; if (rdat !== 8'h03) $display("[TB] FAIL ovr_status_busy: got %h, expected 03", rdat); else passed++;
        waitIdle(tmo);
        modelRx = 8'h5A;
        checks++; if (riseCount - r0 !== 8) $display("[TB] FAIL ovr_rises: got %0d, expected 8", riseCount - r0); else passed++;
        checks++; if (mosiBits !== 8'h5A) $display("[TB] FAIL ovr_mosi: got %h, expected 5a", mosiBits); else passed++;
        checks++; if (busyCycles - b0 !== 16) $display("[TB] FAIL ovr_busy: got %0d, expected 16", busyCycles - b0); else passed++;
        applyStimulus(1'b0, PORT_DIV, 8'h00, rdat, ract);
        checks++; if (rdat !== 8'h00) $display("[TB] FAIL ovr_status_idle: got %h, expected 00", rdat); else passed++;
        applyStimulus(1'b0, PORT_DATA, 8'h00, rdat, ract);
        checks++; if (rdat !== modelRx) $display("[TB] FAIL ovr_read: got %h, expected %h", rdat, modelRx); else passed++;
        waitIdle(tmo);
        modelRx = 8'hFF;
    endtask

    task automatic test_cs();
        int b0, n0;
        logic [7:0] rdat;
        logic       ract;
        bit         tmo;
        loopback = 1'b1;
        b0 = busyCycles;
        applyStimulus(1'b1, PORT_DATA, 8'h81, rdat, ract);
        applyStimulus(1'b1, PORT_CTRL, 8'hFE, rdat, ract);
        checks++; if (spi_cs_n !== 2'b10) $display("[TB] FAIL cs_select: got %b, expected 10", spi_cs_n); else passed++;
        checks++; if (spi_wait !== 1'b1) $display("[TB] FAIL cs_during_xfer: busy %b, expected 1", spi_wait); else passed++;
        applyStimulus(1'b1, PORT_CTRL, 8'hFF, rdat, ract);
        checks++; if (spi_cs_n !== 2'b11) $display("[TB] FAIL cs_release: got %b, expected 11", spi_cs_n); else passed++;
        waitIdle(tmo);
        modelRx = 8'h81;
        checks++; if (busyCycles - b0 !== 16) $display("[TB] FAIL cs_busy: got %0d, expected 16", busyCycles - b0); else passed++;
        checks++; if (mosiBits !== 8'h81) $display("[TB] FAIL cs_mosi: got %h, expected 81", mosiBits); else passed++;
        en = 1'b0;
        n0 = busyRises;
        applyStimulus(1'b1, PORT_DATA, 8'h42, rdat, ract);
        repeat (20) @(negedge clk28);
        checks++; if (busyRises - n0 !== 0) $display("[TB] FAIL en_block: got %0d transfers, expected 0", busyRises - n0); else passed++;
        en = 1'b1;
    endtask

    task automatic test_random();
        int         b0;
        int         d;
        logic [7:0] tx;
        logic [7:0] rdat;
        logic       ract;
        bit         tmo;
        loopback = 1'b0;
        for (int it = 0; it < 6; it++) begin
            d         = int'($urandom_range(0, 3));
            tx        = 8'($urandom);
            slaveByte = 8'($urandom);
            applyStimulus(1'b1, PORT_DIV, 8'(d), rdat, ract);
            modelDiv = d;
            b0 = busyCycles;
            applyStimulus(1'b1, PORT_DATA, tx, rdat, ract);
            waitIdle(tmo);
            modelRx = slaveByte;
            checks++; if (busyCycles - b0 !== 16 * (modelDiv + 1)) $display("[TB] FAIL rnd_busy[%0d]: got %0d, expected %0d", it, busyCycles - b0, 16 * (modelDiv + 1)); else passed++;
            checks++; if (mosiBits !== tx) $display("[TB] FAIL rnd_mosi[%0d]: got %h, expected %h", it, mosiBits, tx); else passed++;
            applyStimulus(1'b0, PORT_DATA, 8'h00, rdat, ract);
            checks++; if (rdat !== modelRx) $display("[TB] FAIL rnd_read[%0d]: got %h, expected %h", it, rdat, modelRx); else passed++;
            waitIdle(tmo);
        end
    endtask

    task automatic test_held_read();
        int  n0;
        bit  tmo;
        loopback = 1'b1;
        n0 = busyRises;
        @(negedge clk28);
        bus.ioreq = 1'b1;
        bus.a_reg = {8'h00, PORT_DATA};
        bus.rd    = 1'b1;
        bus.wr    = 1'b0;
        #1;
        checks++; if (d_out_active !== 1'b0) $display("[TB] FAIL hold_dact_lag: got %b, expected 0", d_out_active); else passed++;
        @(negedge clk28);
        checks++; if (d_out_active !== 1'b1) $display("[TB] FAIL hold_dact_rise: got %b, expected 1", d_out_active); else passed++;
        checks++; if (d_out !== modelRx) $display("[TB] FAIL hold_read: got %h, expected %h", d_out, modelRx); else passed++;
        repeat (19) @(negedge clk28);
        checks++; if (d_out_active !== 1'b1) $display("[TB] FAIL hold_dact_hold: got %b, expected 1", d_out_active); else passed++;
        bus.ioreq = 1'b0;
        bus.rd    = 1'b0;
        @(negedge clk28);
        checks++; if (d_out_active !== 1'b0) $display("[TB] FAIL hold_dact_fall: got %b, expected 0", d_out_active); else passed++;
        waitIdle(tmo);
        modelRx = 8'hFF;
        checks++; if (busyRises - n0 !== 1) $display("[TB] FAIL hold_single: got %0d transfers, expected 1", busyRises - n0); else passed++;
    endtask

    task automatic test_reset_mid();
        int         r0, b0;
        bit         hit;
        bit         tmo;
        logic [7:0] rdat;
        logic       ract;
        loopback = 1'b1;
        applyStimulus(1'b1, PORT_DIV, 8'h01, rdat, ract);
        applyStimulus(1'b1, PORT_CTRL, 8'hFE, rdat, ract);
        r0 = riseCount;
        applyStimulus(1'b1, PORT_DATA, 8'h96, rdat, ract);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (riseCount - r0 >= 4) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk28);
        end
        checks++; if (!hit) $display("[TB] FAIL rstmid_reach_bit4: got %0d rises, expected 4", riseCount - r0); else passed++;
        #5 rst_n = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 2'b11) $display("[TB] FAIL rstmid_cs: got %b, expected 11", spi_cs_n); else passed++;
        checks++; if (spi_sck !== 1'b0) $display("[TB] FAIL rstmid_sck: got %b, expected 0", spi_sck); else passed++;
        checks++; if (spi_mosi !== 1'b1) $display("[TB] FAIL rstmid_mosi: got %b, expected 1", spi_mosi); else passed++;
        checks++; if (spi_wait !== 1'b0) $display("[TB] FAIL rstmid_wait: got %b, expected 0", spi_wait); else passed++;
        checks++; if (d_out !== 8'h00) $display("[TB] FAIL rstmid_dout: got %h, expected 00", d_out); else passed++;
        @(negedge clk28);
        rst_n    = 1'b1;
        modelDiv = 0;
        modelRx  = 8'hFF;
        b0 = busyCycles;
        applyStimulus(1'b0, PORT_DATA, 8'h00, rdat, ract);
        checks++; if (rdat !== modelRx) $display("[TB] FAIL rstmid_rx: got %h, expected %h", rdat, modelRx); else passed++;
        waitIdle(tmo);
        checks++; if (busyCycles - b0 !== 16 * (modelDiv + 1)) $display("[TB] FAIL rstmid_div: got %0d, expected %0d", busyCycles - b0, 16 * (modelDiv + 1)); else passed++;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_write_loopback();
        test_divider();
        test_overrun();
        test_cs();
        test_random();
        test_held_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
